// File: rtl/word_unloader.sv
// word_unloader: captures up to NUM_WORDS words in one cycle and streams them out over valid/ready
module word_unloader #(
    parameter int WORD_SIZE = 64,
    parameter int NUM_WORDS = 4,
    parameter int CNT_W = $clog2(NUM_WORDS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           capture_i,
    input  logic [CNT_W-1:0]               num_words_i,
    input  logic [NUM_WORDS*WORD_SIZE-1:0] data_i,
    output logic                           busy_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [WORD_SIZE-1:0]           out_data_o,
    output logic                           out_last_o,
    output logic                           done_o
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state_q, state_d;
    logic [NUM_WORDS*WORD_SIZE-1:0] buf_q;
    logic [CNT_W-1:0] count_q, idx_q;
    logic accept, empty, xfer, last;
    assign accept = state_q == IDLE && capture_i && num_words_i != '0;
    assign empty = state_q == IDLE && capture_i && num_words_i == '0;
    assign last = idx_q == count_q - CNT_W'(1);
    assign xfer = out_valid_o && out_ready_i;
    assign busy_o = state_q == STREAM;
    assign out_valid_o = state_q == STREAM;
    assign out_last_o = out_valid_o && last;
    assign out_data_o = buf_q[idx_q*WORD_SIZE +: WORD_SIZE];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (accept) state_d = STREAM;
        else if (xfer && last) state_d = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            count_q <= '0;
            idx_q <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= empty || (xfer && last);
            if (accept) begin
                buf_q <= data_i;
                count_q <= num_words_i > CNT_W'(NUM_WORDS) ? CNT_W'(NUM_WORDS) : num_words_i;
                idx_q <= '0;
            end else if (xfer && !last) begin
                idx_q <= idx_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_word_unloader.sv
// tb_word_unloader: directed checks of capture, streaming, backpressure, clamp, busy capture and reset
module tb_word_unloader;
    logic clk = 1'b0, reset = 1'b1, capture_i = 1'b0, out_ready_i = 1'b0;
    logic [2:0] num_words_i = '0;
    logic [255:0] data_i = '0;
    logic busy_o, out_valid_o, out_last_o, done_o;
    logic [63:0] out_data_o;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    word_unloader dut (
        .clk(clk), .reset(reset), .capture_i(capture_i), .num_words_i(num_words_i),
        .data_i(data_i), .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .done_o(done_o)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic word(input string tag, input logic [63:0] d, input logic l);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        chk({tag, "_data"}, out_data_o, d);
        chk({tag, "_last"}, 64'(out_last_o), 64'(l));
        chk({tag, "_done"}, 64'(done_o), 64'd0);
    endtask
    task automatic finished(input string tag);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd1);
    endtask
    task automatic cap(input logic [2:0] n, input logic [63:0] w3, w2, w1, w0);
        num_words_i = n;
        data_i = {w3, w2, w1, w0};
        capture_i = 1'b1;
        step();
        capture_i = 1'b0;
    endtask
    initial begin
        #12;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data", out_data_o, 64'd0);
        chk("rst_last", 64'(out_last_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        reset = 1'b0;
        step();
        out_ready_i = 1'b1;
        cap(3'd4, 64'h4, 64'h3, 64'h2, 64'h1);
        for (int k = 0; k < 4; k++) begin
            word("basic", 64'(k + 1), k == 3);
            step();
        end
        finished("basic_end");
        step();
        chk("basic_done_pulse", 64'(done_o), 64'd0);
        out_ready_i = 1'b0;
        cap(3'd2, 64'h0, 64'h0, 64'hB, 64'hA);
        for (int k = 0; k < 3; k++) begin
            word("stall", 64'hA, 1'b0);
            step();
        end
        out_ready_i = 1'b1;
        word("bp_w0", 64'hA, 1'b0);
        step();
        word("bp_w1", 64'hB, 1'b1);
        step();
        finished("bp_end");
        step();
        cap(3'd7, 64'h24, 64'h23, 64'h22, 64'h21);
        for (int k = 0; k < 4; k++) begin
            word("clamp", 64'(k + 'h21), k == 3);
            step();
        end
        finished("clamp_end");
        step();
        cap(3'd0, 64'h9, 64'h9, 64'h9, 64'h9);
        finished("zero");
        step();
        chk("zero_done_pulse", 64'(done_o), 64'd0);
        chk("zero_valid2", 64'(out_valid_o), 64'd0);
        cap(3'd3, 64'h0, 64'h33, 64'h22, 64'h11);
        word("busy_w0", 64'h11, 1'b0);
        num_words_i = 3'd2;
        data_i = {4{64'hEE}};
        capture_i = 1'b1;
        step();
        word("busy_w1", 64'h22, 1'b0);
        step();
        word("busy_w2", 64'h33, 1'b1);
        step();
        capture_i = 1'b0;
        finished("busy_end");
        cap(3'd1, 64'h0, 64'h0, 64'h0, 64'h55);
        word("after_busy", 64'h55, 1'b1);
        step();
        finished("after_busy_end");
        step();
        cap(3'd4, 64'hD4, 64'hD3, 64'hD2, 64'hD1);
        word("mid_w0", 64'hD1, 1'b0);
        step();
        word("mid_w1", 64'hD2, 1'b0);
        step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_data", out_data_o, 64'd0);
        chk("mid_rst_last", 64'(out_last_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        #1 reset = 1'b0;
        step();
        chk("post_rst_valid", 64'(out_valid_o), 64'd0);
        chk("post_rst_done", 64'(done_o), 64'd0);
        cap(3'd2, 64'h0, 64'h0, 64'hA2, 64'hA1);
        word("fresh_w0", 64'hA1, 1'b0);
        step();
        word("fresh_w1", 64'hA2, 1'b1);
        step();
        finished("fresh_end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
